// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander.
// Accepts one padded 512-bit block, then streams W0..W63 one word per beat
// using a 16-word sliding window. One block in flight at a time.
module sha256_msg_schedule #(
    parameter int P_S_AXIS_DATA_WIDTH = 512,
    parameter int P_M_AXIS_DATA_WIDTH = 32,
    parameter int ROUNDS              = 64
) (
    input  logic                           axi_aclk,
    input  logic                           reset,
    input  logic [P_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [P_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [$clog2(ROUNDS):0]        m_axis_tuser
);

    localparam int WW = P_M_AXIS_DATA_WIDTH;
    localparam int NW = P_S_AXIS_DATA_WIDTH / P_M_AXIS_DATA_WIDTH;
    localparam int TW = $clog2(ROUNDS);
    localparam logic [TW-1:0] T_LAST = TW'(ROUNDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [TW-1:0] t;
    logic          msg_last;
    logic [WW-1:0] w [0:NW-1];
    logic [WW-1:0] w_new;

    function automatic logic [WW-1:0] rotr(input logic [WW-1:0] x, input int n);
        return (x >> n) | (x << (WW - n));
    endfunction

    function automatic logic [WW-1:0] sig0(input logic [WW-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WW-1:0] sig1(input logic [WW-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Next schedule word from the window: W[t+16] in terms of w[0..15] = W[t..t+15].
    always_comb begin
        w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    end

    // Outputs come straight from state and window registers; reset masks them
    // so nothing looks valid/ready while reset is held.
    assign s_axis_tready = (state == IDLE) && !reset;
    assign m_axis_tvalid = (state == RUN) && !reset;
    assign m_axis_tlast  = (state == RUN) && (t == T_LAST) && !reset;
    assign m_axis_tdata  = reset ? '0 : w[0];
    assign m_axis_tuser  = {msg_last, t};

    // Control FSM plus window load/shift.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state    <= IDLE;
            t        <= '0;
            msg_last <= 1'b0;
            for (int i = 0; i < NW; i++) w[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        // First word sits in the MSBs of the block.
                        for (int i = 0; i < NW; i++)
                            w[i] <= s_axis_tdata[P_S_AXIS_DATA_WIDTH-1-WW*i -: WW];
                        msg_last <= s_axis_tlast;
                        t        <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (m_axis_tready) begin
                        for (int i = 0; i < NW-1; i++) w[i] <= w[i+1];
                        w[NW-1] <= w_new;
                        if (t == T_LAST) begin
                            t     <= '0;
                            state <= IDLE;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Sits directly downstream of the SHA padder. Consumes one padded 512-bit message block per AXI-Stream beat.
- Expands each block into the 64 SHA-256 schedule words W0..W63 and streams them one 32-bit word per beat to the compression round stage.
- Uses a 16-word sliding window, so only one block is held at a time.

Parameters:
- P_S_AXIS_DATA_WIDTH, 512, input block width; only 512 is supported.
- P_M_AXIS_DATA_WIDTH, 32, output word width; only 32 is supported.
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- axi_aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  512  padded message block.
- s_axis_tvalid  in  1  input block valid.
- s_axis_tready  out  1  input ready; high only in IDLE.
- s_axis_tlast  in  1  marks the final block of a message.
- m_axis_tdata  out  32  current schedule word W[t].
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high with W63.
- m_axis_tuser  out  7  bits [5:0] = round index t; bit [6] = message-last flag, captured from s_axis_tlast and constant across the whole block.

Behaviour:
- Reset (axi_aclk edge with reset=1):
  - state goes to IDLE; round counter t = 0; window cleared; msg_last flag = 0.
  - Output values while reset is asserted: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - From the first cycle after reset is released: s_axis_tready=1 (IDLE).
  - Reset mid-block discards the block; nothing resumes.
- Word order: W0 = s_axis_tdata[511:480], W1 = [479:448], ..., W15 = [31:0] (big-endian, first word in the MSBs).
- States:
  - IDLE:
    - s_axis_tready=1, m_axis_tvalid=0.
    - On s_axis_tvalid&s_axis_tready: load window w[0..15]=W0..W15, capture msg_last=s_axis_tlast, set t=0, go to RUN.
  - RUN:
    - s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=w[0], tuser={msg_last,t}, m_axis_tlast=(t==63).
    - On m_axis_tvalid&m_axis_tready: shift w[i]<=w[i+1] for i=0..14, set w[15]<=Wnew, t<=t+1.
    - Wnew = s1(w[14]) + w[9] + s0(w[1]) + w[0], mod 2^32 (carries discarded).
    - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
    - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
    - On handshake at t==63: go to IDLE, t<=0.
    - Window update may be ungated (result unused) but must not corrupt the next load.
- Latency and throughput:
  - W0 is valid the cycle after input acceptance.
  - Sustained rate is 65 cycles per block: 64 output beats plus 1 IDLE accept cycle.
  - No overlap between consecutive blocks.
- Backpressure:
  - While m_axis_tvalid=1 and m_axis_tready=0, tdata, tuser and tlast are held stable; t and the window do not advance.
  - tvalid never deasserts before its handshake.
- Boundary conditions:
  - s_axis_tvalid while in RUN is ignored (tready=0), and the upstream block is held by AXI rules.
  - A simultaneous input valid on the cycle RUN exits is not accepted until the following IDLE cycle.
  - t is 6 bits and wraps 63->0 only via the transition to IDLE.
  - tready is derived from registered state only, with no combinational path from s_axis_tvalid.

Test Plan:
- Reset, then one "abc" padded block (0x61626380, 14 words 0x00000000, 0x00000018), tlast=1, tready held high -> exactly 64 output beats; W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000f0000; tlast only on beat 63; tuser[6]=1 on all beats; tuser[5:0]=0..63; W18..W63 match the software model.
- Same block with random m_axis_tready (50% duty) -> identical word sequence; data stable across stall cycles; no words dropped or duplicated.
- Two back-to-back blocks (first tlast=0, second tlast=1) with s_axis_tvalid held high -> second block accepted exactly 1 cycle after W63 of the first; tuser[6]=0 for the first block and 1 for the second; per-block words match the model.
- Block of all 0xFF bytes -> all W16..W63 match the model, exercising mod-2^32 carry discard.
- Assert reset at t=30 mid-block -> the next cycle has tvalid=0 and state IDLE; tready=1 once reset is released; a fresh block then restarts at W0 with t=0.
- s_axis_tvalid asserted during RUN with a different block -> not accepted (tready=0) until IDLE; the current block's output is unaffected.
